instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  ARM-subset IF stage, directly upstream of the ID stage. Fetches 32-bit words from an instruction memory
//  over a req/response handshake and holds one instruction in an output slot for the IF/ID register.
//  Obeys the hazard freeze and the EX branch redirect. Output pcOut = fetch address + 4.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value after reset
//  PC_STEP    4               PC increment per accepted instruction
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  freeze       in   1   hazard: IF/ID not accepting; output slot must hold
//  branchTaken  in   1   EX redirect pulse
//  branchAddr   in   32  redirect target
//  imemReq      out  1   one-cycle request pulse
//  imemAddr     out  32  fetch address; stable while a request is outstanding
//  imemRspValid in   1   one-cycle response pulse, >=1 cycle after imemReq
//  imemRspData  in   32  instruction word, valid with imemRspValid
//  pcOut        out  32  fetch address + 4 of the held instruction
//  instOut      out  32  held instruction
//  instValid    out  1   output slot occupied
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=S_REQ, drop=0, instValid=0, pcOut=0, instOut=0, imemReq=0 in the reset cycle.
//  - At most one outstanding request. Responses arriving outside S_WAIT are ignored.
//  - Slot free this cycle: slotFree = ~instValid | ~freeze.
//  - The slot is consumed when instValid & ~freeze; instValid then drops unless it is refilled in the same cycle.
//  - FSM:
//    - S_REQ: imemReq = ~branchTaken, with imemAddr = pc; if issued -> S_WAIT.
//    - S_WAIT, response, drop=1: drop<=0 -> S_REQ.
//    - S_WAIT, response, drop=0, slotFree: slot <= {pc+4, data}, pc <= pc+PC_STEP -> S_REQ.
//    - S_WAIT, response, drop=0, ~slotFree: pendBuf <= data -> S_PEND.
//    - S_PEND, slotFree: slot <= {pc+4, pendBuf}, pc += PC_STEP -> S_REQ.
//  - Branch has priority over freeze and over any response in the same cycle:
//    - pc <= branchAddr; instValid <= 0.
//    - S_REQ: no request issued that cycle; stay in S_REQ.
//    - S_WAIT without response: drop <= 1; stay in S_WAIT.
//    - S_WAIT with response: discard the data -> S_REQ, drop=0.
//    - S_PEND: pendBuf discarded -> S_REQ.
//  - Two branches while one request is outstanding: drop stays 1, last target wins. Exactly one response is dropped.
//  - pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). pcOut uses the same modular add.
//  - Throughput: 1 instruction / 2 cycles with 1-cycle memory latency.
//  - Latency: response to instValid = 1 cycle when the slot is free.
//  - Reset mid-operation returns to the reset state. The memory shares rst, so no stale response follows.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - adds out ports fetchCount[31:0] (slot loads) and flushCount[31:0] (branch cycles that killed a slot,
//      pendBuf or in-flight request).
//    - Both counters reset to 0 and wrap.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  - Shared package/header fetch_pkg: state encodings S_REQ=2'd0, S_WAIT=2'd1, S_PEND=2'd2; PC_STEP default.
//  - One sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_EN.
//  - FSM, pc, drop, pendBuf and output slot live in the top module.
// TESTING
//  - Reset then 1-cycle memory returning addr-tagged words -> imemAddr 0,4,8; instOut matches; pcOut 4,8,12;
//    one instruction every 2 cycles.
//  - freeze held 5 cycles with instValid=1 -> slot unchanged, response parked in S_PEND. Release -> next inst
//    the following cycle; none lost or duplicated.
//  - branchTaken(0x100) in S_WAIT, response 3 cycles later -> response dropped, instValid=0, next imemAddr=0x100.
//  - branchTaken coincident with response and with freeze -> slot flushed, imemAddr=target, no stale pcOut.
//  - pc=0xFFFF_FFFC fetch -> pcOut=0, next imemAddr=0.
//  - rst asserted in S_PEND -> all outputs zero next cycle, first request to RESET_PC; with FETCH_PERF_EN
//    counters zero.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width, default
// PC increment, fetch FSM state encodings and the IF/ID output slot payload.
package fetch_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_PEND = 2'd2
  } fetch_state_e;

  // Instruction held for the IF/ID register: pc is fetch address + 4.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running, wrapping event counters for the fetch stage.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fetch_inc          one-cycle pulse per output slot load
//   flush_inc          one-cycle pulse per branch cycle that killed work
//   fetch_count        number of slot loads since reset
//   flush_count        number of killing branch cycles since reset
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_inc,
  input  logic            flush_inc,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] flush_count
);

  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] flush_count_q, flush_count_d;

  // Counter increments; both wrap modulo 2^XLEN.
  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (fetch_inc) fetch_count_d = fetch_count_q + XLEN'(1);
    if (flush_inc) flush_count_d = flush_count_q + XLEN'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: fetches 32-bit words over a req/response handshake with at most one
// outstanding request, and holds one instruction in an output slot for IF/ID.
// Honours the hazard freeze and the EX branch redirect (branch has priority).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   freeze                         IF/ID not accepting; output slot holds
//   branchTaken, branchAddr        redirect pulse and target
//   imemReq, imemAddr              request pulse and fetch address
//   imemRspValid, imemRspData      response pulse and instruction word
//   pcOut, instOut, instValid      output slot (pcOut = fetch address + 4)
//   fetchCount, flushCount         perf counters, only with FETCH_PERF_EN
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchAddr,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemRspValid,
  input  logic [XLEN-1:0] imemRspData,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] instOut,
  output logic            instValid
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] fetchCount,
  output logic [XLEN-1:0] flushCount
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            drop_q, drop_d;
  logic            valid_q, valid_d;
  fetch_slot_t     slot_q, slot_d;
  logic            slot_free;
  logic            issue;

  // Next-state, slot and request logic; a branch overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    slot_d     = slot_q;
    // Slot is consumed whenever it is occupied and not frozen.
    valid_d    = valid_q & freeze;
    issue      = 1'b0;
    slot_free  = ~valid_q | ~freeze;

    if (branchTaken) begin
      pc_d    = branchAddr;
      valid_d = 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (imemRspValid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            // Response still in flight: kill exactly that one when it lands.
            drop_d  = 1'b1;
          end
        end
        S_PEND:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          issue      = 1'b1;
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (imemRspValid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (slot_free) begin
              slot_d  = '{pc: pc_q + XLEN'(4), inst: imemRspData};
              valid_d = 1'b1;
              pc_d    = pc_q + XLEN'(PC_STEP);
              state_d = S_REQ;
            end else begin
              pend_d  = imemRspData;
              state_d = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (slot_free) begin
            slot_d  = '{pc: pc_q + XLEN'(4), inst: pend_q};
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(PC_STEP);
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_q     <= '0;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      slot_q     <= slot_d;
    end
  end

  // Request is issued in the same cycle the FSM sits in S_REQ so a 1-cycle
  // memory sustains one instruction every two cycles. The address is held in
  // req_addr_q while outstanding because a branch may move pc underneath it.
  assign imemReq   = issue & ~rst;
  assign imemAddr  = (state_q == S_REQ) ? pc_q : req_addr_q;
  assign pcOut     = slot_q.pc;
  assign instOut   = slot_q.inst;
  assign instValid = valid_q;

`ifdef FETCH_PERF_EN
  logic load_ev;
  logic flush_ev;

  // A load is the only way valid_d rises other than holding a frozen slot.
  assign load_ev  = valid_d & ~(valid_q & freeze);
  // Killed work: an occupied slot, a parked word, or a not-yet-doomed request.
  assign flush_ev = branchTaken &
                    (valid_q | (state_q == S_PEND) | ((state_q == S_WAIT) & ~drop_q));

  fetch_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .fetch_inc  (load_ev),
    .flush_inc  (flush_ev),
    .fetch_count(fetchCount),
    .flush_count(flushCount)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a small latency-programmable
// memory responder returning address-tagged words.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        instValid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] flushCount;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Memory responder state
  bit          outstanding = 1'b0;
  int          wait_left   = 0;
  int          lat         = 1;
  logic [31:0] mem_addr    = '0;
  logic        seen_req;
  logic [31:0] seen_addr;

  instruction_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branchTaken (branchTaken),
    .branchAddr  (branchAddr),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemRspValid(imemRspValid),
    .imemRspData (imemRspData),
    .pcOut       (pcOut),
    .instOut     (instOut),
    .instValid   (instValid)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount  (fetchCount),
    .flushCount  (flushCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tg(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present any due response, record the request seen before
  // the edge, advance to the next falling edge.
  task automatic cyc();
    if (outstanding && wait_left == 0) begin
      imemRspValid = 1'b1;
      imemRspData  = tg(mem_addr);
      outstanding  = 1'b0;
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = '0;
      if (outstanding) wait_left--;
    end
    #1;
    seen_req  = imemReq;
    seen_addr = imemAddr;
    if (imemReq && !rst) begin
      outstanding = 1'b1;
      mem_addr    = imemAddr;
      wait_left   = lat - 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) outstanding = 1'b0;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst);
    check({tag, "_valid"}, 32'(instValid), 32'(v));
    check({tag, "_pc"}, pcOut, pc);
    check({tag, "_inst"}, instOut, inst);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branchTaken = 1'b0; branchAddr = '0;
    imemRspValid = 1'b0; imemRspData = '0;
    @(negedge clk);

    // Reset
    cyc();
    check("rst_req", 32'(seen_req), 32'd0);
    cyc();
    rst = 1'b0;
    check_slot("rst", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_fetchcnt", fetchCount, 32'd0);
    check("rst_flushcnt", flushCount, 32'd0);
`endif

    // Streaming with 1-cycle memory: one instruction every two cycles
    cyc(); check("f0_req", 32'(seen_req), 32'd1); check("f0_addr", seen_addr, 32'h0);
    check("f0_gap", 32'(instValid), 32'd0);
    cyc(); check_slot("f0", 1'b1, 32'h4, tg(32'h0));
    cyc(); check("f1_addr", seen_addr, 32'h4); check("f1_gap", 32'(instValid), 32'd0);
    cyc(); check_slot("f1", 1'b1, 32'h8, tg(32'h4));
    cyc(); check("f2_addr", seen_addr, 32'h8);
    cyc(); check_slot("f2", 1'b1, 32'hC, tg(32'h8));

    // Freeze 5 cycles: slot holds, next word parks in S_PEND
    freeze = 1'b1;
    cyc(); check("fz_addr", seen_addr, 32'hC); check_slot("fz0", 1'b1, 32'hC, tg(32'h8));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("fz_noreq", 32'(seen_req), 32'd0);
      check_slot("fz_hold", 1'b1, 32'hC, tg(32'h8));
    end
    freeze = 1'b0;
    cyc(); check_slot("fz_rel", 1'b1, 32'h10, tg(32'hC));
    cyc(); check("fz_next_addr", seen_addr, 32'h10); check("fz_next_gap", 32'(instValid), 32'd0);
    cyc(); check_slot("fz_next", 1'b1, 32'h14, tg(32'h10));

    // Branch while waiting on a 3-cycle response: that response is dropped
    lat = 3;
    cyc(); check("bw_addr", seen_addr, 32'h14);
    branchTaken = 1'b1; branchAddr = 32'h100;
    cyc(); branchTaken = 1'b0;
    check("bw_valid0", 32'(instValid), 32'd0);
    cyc(); check("bw_noreq", 32'(seen_req), 32'd0); check("bw_addr_stable", seen_addr, 32'h14);
    cyc(); check("bw_dropped", 32'(instValid), 32'd0);
    lat = 1;
    cyc(); check("bw_req", 32'(seen_req), 32'd1); check("bw_target", seen_addr, 32'h100);
    cyc(); check_slot("bw_tgt", 1'b1, 32'h104, tg(32'h100));

    // Branch coincident with response and freeze
    freeze = 1'b1;
    cyc(); check("bc_addr", seen_addr, 32'h104); check_slot("bc_hold", 1'b1, 32'h104, tg(32'h100));
    branchTaken = 1'b1; branchAddr = 32'h200;
    cyc(); branchTaken = 1'b0; freeze = 1'b0;
    check("bc_flush", 32'(instValid), 32'd0);
    cyc(); check("bc_target", seen_addr, 32'h200); check("bc_gap", 32'(instValid), 32'd0);
    cyc(); check_slot("bc_tgt", 1'b1, 32'h204, tg(32'h200));

    // Branch in S_REQ suppresses the request; then wrap at top of address space
    branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC;
    cyc(); branchTaken = 1'b0;
    check("br_noreq", 32'(seen_req), 32'd0); check("br_flush", 32'(instValid), 32'd0);
    cyc(); check("wr_addr", seen_addr, 32'hFFFF_FFFC);
    cyc(); check_slot("wr", 1'b1, 32'h0, tg(32'hFFFF_FFFC));
    cyc(); check("wr_next", seen_addr, 32'h0);
    cyc(); check_slot("wr2", 1'b1, 32'h4, tg(32'h0));

    // Reset while in S_PEND
    freeze = 1'b1;
    cyc(); check("rp_addr", seen_addr, 32'h4);
    cyc(); check_slot("rp_hold", 1'b1, 32'h4, tg(32'h0));
    rst = 1'b1;
    cyc(); rst = 1'b0; freeze = 1'b0;
    check("rp_noreq", 32'(seen_req), 32'd0);
    check_slot("rp", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    check("rp_fetchcnt", fetchCount, 32'd0);
    check("rp_flushcnt", flushCount, 32'd0);
`endif

    // Two branches with one request outstanding: last target wins
    lat = 3;
    cyc(); check("db_req", 32'(seen_req), 32'd1); check("db_addr", seen_addr, 32'h0);
    branchTaken = 1'b1; branchAddr = 32'h40;
    cyc();
    branchAddr = 32'h80;
    cyc(); branchTaken = 1'b0;
    cyc(); check("db_dropped", 32'(instValid), 32'd0);
    lat = 1;
    cyc(); check("db_req2", 32'(seen_req), 32'd1); check("db_target", seen_addr, 32'h80);
    cyc(); check_slot("db_tgt", 1'b1, 32'h84, tg(32'h80));
`ifdef FETCH_PERF_EN
    check("end_fetchcnt", fetchCount, 32'd1);
    check("end_flushcnt", flushCount, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
